// File: rtl/lap_countdown_timer.sv
// Stopwatch / countdown timer with a prescaled tick, a lap FIFO and a ring output.
// All outputs are registers; event priority is startOrStop > splitOrReset > modeInput.
module lap_countdown_timer #(
  parameter int CLK_DIV   = 1000000,
  parameter int COUNT_W   = 32,
  parameter int LAP_DEPTH = 8
) (
  input  logic               clockSignal,
  input  logic               reset,
  input  logic               modeInput,
  input  logic               startOrStop,
  input  logic               splitOrReset,
  input  logic [COUNT_W-1:0] loadValue,
  input  logic               lapRead,
  output logic [COUNT_W-1:0] timeCount,
  output logic               mode,
  output logic               running,
  output logic               ringSound,
  output logic [COUNT_W-1:0] lapData,
  output logic               lapValid,
  output logic               lapOverflow
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {STOPPED, RUNNING, RINGING} state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      prescaler, prescaler_nx;
  logic [COUNT_W-1:0] count_nx;
  logic               mode_nx;
  logic               tick, start_ev, split_ev, mode_ev;
  logic               flush, push, pop;

  // Lap FIFO as a shift register: slot 0 is always the head and reads 0 when empty.
  logic [COUNT_W-1:0] lap_mem    [LAP_DEPTH];
  logic [COUNT_W-1:0] lap_mem_nx [LAP_DEPTH];
  logic [CW-1:0]      lap_cnt, lap_cnt_nx;
  logic               ovf_nx;

  always_comb begin
    start_ev = startOrStop;
    split_ev = splitOrReset & ~startOrStop;
    mode_ev  = modeInput & ~startOrStop & ~splitOrReset;
    tick     = (state == RUNNING) && (prescaler == PRE_MAX);
  end

  always_comb begin
    state_nx = state;
    count_nx = timeCount;
    mode_nx  = mode;
    flush    = 1'b0;
    push     = 1'b0;
    unique case (state)
      STOPPED: begin
        if (start_ev) begin
          if (!(mode && timeCount == '0)) state_nx = RUNNING;
        end else if (split_ev) begin
          if (mode) begin
            count_nx = loadValue;
          end else begin
            count_nx = '0;
            flush    = 1'b1;
          end
        end else if (mode_ev) begin
          mode_nx  = ~mode;
          count_nx = '0;
          flush    = 1'b1;
        end
      end
      RUNNING: begin
        if (tick) count_nx = mode ? timeCount - COUNT_W'(1) : timeCount + COUNT_W'(1);
        if (start_ev) state_nx = STOPPED;
        if (split_ev && !mode) push = 1'b1;
        // Reaching zero rings even if a stop arrives on the same edge.
        if (tick && mode && timeCount == COUNT_W'(1)) state_nx = RINGING;
      end
      RINGING: begin
        if (startOrStop || splitOrReset || modeInput) state_nx = STOPPED;
      end
      default: state_nx = STOPPED;
    endcase
  end

  always_comb begin
    prescaler_nx = '0;
    if (state == RUNNING && state_nx == RUNNING && !tick) prescaler_nx = prescaler + PW'(1);
  end

  always_comb begin
    pop        = lapRead && (lap_cnt != '0) && !flush;
    lap_mem_nx = lap_mem;
    lap_cnt_nx = lap_cnt;
    ovf_nx     = lapOverflow;
    if (flush) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem_nx[i] = '0;
      lap_cnt_nx = '0;
      ovf_nx     = 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < LAP_DEPTH - 1; i++) lap_mem_nx[i] = lap_mem[i+1];
        lap_mem_nx[LAP_DEPTH-1] = '0;
        lap_cnt_nx = lap_cnt - CW'(1);
      end
      if (push) begin
        if (lap_cnt_nx < DEPTH) begin
          lap_mem_nx[lap_cnt_nx[AW-1:0]] = timeCount;
          lap_cnt_nx = lap_cnt_nx + CW'(1);
        end else begin
          ovf_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clockSignal) begin
    if (reset) begin
      state       <= STOPPED;
      prescaler   <= '0;
      timeCount   <= '0;
      mode        <= 1'b0;
      running     <= 1'b0;
      ringSound   <= 1'b0;
      lap_cnt     <= '0;
      lapValid    <= 1'b0;
      lapOverflow <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
    end else begin
      state       <= state_nx;
      prescaler   <= prescaler_nx;
      timeCount   <= count_nx;
      mode        <= mode_nx;
      running     <= (state_nx == RUNNING);
      ringSound   <= (state_nx == RINGING);
      lap_cnt     <= lap_cnt_nx;
      lapValid    <= (lap_cnt_nx != '0);
      lapOverflow <= ovf_nx;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= lap_mem_nx[i];
    end
  end

  assign lapData = lap_mem[0];

endmodule

// File: tb/tb_lap_countdown_timer.sv
// Scenario bench for lap_countdown_timer: instance a (CLK_DIV=4, 8-bit, 2 laps)
// and instance b (CLK_DIV=1, 4-bit) for the wrap case.
module tb_lap_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_mode_in = 0, a_start = 0, a_split = 0, a_read = 0;
  logic [7:0] a_load = 0;
  logic [7:0] a_tc, a_ld;
  logic       a_mode, a_run, a_ring, a_lv, a_ovf;

  logic       b_mode_in = 0, b_start = 0, b_split = 0, b_read = 0;
  logic [3:0] b_load = 0;
  logic [3:0] b_tc, b_ld;
  logic       b_mode, b_run, b_ring, b_lv, b_ovf;

  lap_countdown_timer #(.CLK_DIV(4), .COUNT_W(8), .LAP_DEPTH(2)) dut_a (
    .clockSignal(clk), .reset(rst), .modeInput(a_mode_in), .startOrStop(a_start),
    .splitOrReset(a_split), .loadValue(a_load), .lapRead(a_read), .timeCount(a_tc),
    .mode(a_mode), .running(a_run), .ringSound(a_ring), .lapData(a_ld),
    .lapValid(a_lv), .lapOverflow(a_ovf));

  lap_countdown_timer #(.CLK_DIV(1), .COUNT_W(4), .LAP_DEPTH(2)) dut_b (
    .clockSignal(clk), .reset(rst), .modeInput(b_mode_in), .startOrStop(b_start),
    .splitOrReset(b_split), .loadValue(b_load), .lapRead(b_read), .timeCount(b_tc),
    .mode(b_mode), .running(b_run), .ringSound(b_ring), .lapData(b_ld),
    .lapValid(b_lv), .lapOverflow(b_ovf));

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; step(); rst = 0;
    total++;
    if (a_tc !== 0 || a_mode !== 0 || a_run !== 0 || a_ring !== 0 || a_ld !== 0 || a_lv !== 0 || a_ovf !== 0) begin
      bad++;
      $display("FAIL reset_a tc=%0d mode=%b run=%b ring=%b ld=%0d lv=%b ovf=%b, required all 0",
               a_tc, a_mode, a_run, a_ring, a_ld, a_lv, a_ovf);
    end
    total++;
    if (b_tc !== 0 || b_mode !== 0 || b_run !== 0 || b_ring !== 0 || b_ld !== 0 || b_lv !== 0 || b_ovf !== 0) begin
      bad++;
      $display("FAIL reset_b tc=%0d mode=%b run=%b ring=%b ld=%0d lv=%b ovf=%b, required all 0",
               b_tc, b_mode, b_run, b_ring, b_ld, b_lv, b_ovf);
    end
  endtask

  task automatic test_stopwatch();
    logic [7:0] exp_tc;
    logic exp_run;
    a_start = 1; step(); a_start = 0;
    total++;
    if (a_run !== 1'b1) begin bad++; $display("FAIL sw_start running=%b required 1", a_run); end
    for (int e = 1; e <= 20; e++) begin
      a_start = (e == 10); step(); a_start = 0;
      exp_tc  = (e >= 8) ? 8'd2 : (e >= 4) ? 8'd1 : 8'd0;
      exp_run = (e < 10);
      total++;
      if (a_tc !== exp_tc || a_run !== exp_run) begin
        bad++;
        $display("FAIL sw_edge%0d tc=%0d run=%b required tc=%0d run=%b", e, a_tc, a_run, exp_tc, exp_run);
      end
    end
    a_split = 1; step(); a_split = 0;
    total++;
    if (a_tc !== 0) begin bad++; $display("FAIL sw_clear tc=%0d required 0", a_tc); end
  endtask

  // Splits at edges 5, 9, 13, optional pop at rd_edge, stop at 16; then drain.
  task automatic run_laps(input int rd_edge, input string tag);
    logic exp_ovf;
    q.delete();
    exp_ovf = 0;
    a_start = 1; step(); a_start = 0;
    for (int e = 1; e <= 16; e++) begin
      a_split = (e == 5 || e == 9 || e == 13);
      a_read  = (e == rd_edge);
      a_start = (e == 16);
      if (a_read && q.size() > 0) begin
        total++;
        if (a_ld !== q[0]) begin bad++; $display("FAIL %s head_at_pop ld=%0d required %0d", tag, a_ld, q[0]); end
        void'(q.pop_front());
      end
      if (a_split) begin
        if (q.size() < 2) q.push_back(8'((e - 1) / 4));
        else exp_ovf = 1;
      end
      step();
      a_split = 0; a_read = 0; a_start = 0;
    end
    total++;
    if (a_ovf !== exp_ovf || a_run !== 1'b0) begin
      bad++;
      $display("FAIL %s overflow ovf=%b run=%b required ovf=%b run=0", tag, a_ovf, a_run, exp_ovf);
    end
    while (q.size() > 0) begin
      total++;
      if (a_lv !== 1'b1 || a_ld !== q[0]) begin
        bad++;
        $display("FAIL %s drain lv=%b ld=%0d required lv=1 ld=%0d", tag, a_lv, a_ld, q[0]);
      end
      void'(q.pop_front());
      a_read = 1; step(); a_read = 0;
    end
    total++;
    if (a_lv !== 1'b0 || a_ld !== 0) begin
      bad++; $display("FAIL %s empty lv=%b ld=%0d required lv=0 ld=0", tag, a_lv, a_ld);
    end
    a_read = 1; step(); a_read = 0;
    total++;
    if (a_lv !== 1'b0 || a_ld !== 0 || a_ovf !== exp_ovf) begin
      bad++; $display("FAIL %s pop_empty lv=%b ld=%0d ovf=%b required 0 0 %b", tag, a_lv, a_ld, a_ovf, exp_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    run_laps(13, "pushpop");
    a_split = 1; step(); a_split = 0;
    total++;
    if (a_tc !== 0) begin bad++; $display("FAIL pushpop_clear tc=%0d required 0", a_tc); end
  endtask

  task automatic test_lap_overflow();
    run_laps(0, "overflow");
    a_mode_in = 1; step(); a_mode_in = 0;
    total++;
    if (a_mode !== 1'b1 || a_tc !== 0 || a_ovf !== 1'b0 || a_lv !== 1'b0) begin
      bad++;
      $display("FAIL mode_flush mode=%b tc=%0d ovf=%b lv=%b required 1 0 0 0", a_mode, a_tc, a_ovf, a_lv);
    end
  endtask

  task automatic test_timer();
    logic [7:0] exp_tc;
    logic exp_run, exp_ring;
    a_start = 1; step(); a_start = 0;
    total++;
    if (a_run !== 1'b0) begin bad++; $display("FAIL timer_zero_start running=%b required 0", a_run); end
    a_load = 8'd3; a_split = 1; step(); a_split = 0;
    total++;
    if (a_tc !== 8'd3) begin bad++; $display("FAIL timer_load tc=%0d required 3", a_tc); end
    a_start = 1; step(); a_start = 0;
    for (int e = 1; e <= 20; e++) begin
      a_mode_in = (e == 2);
      a_start   = (e == 20);
      step();
      a_mode_in = 0; a_start = 0;
      exp_tc   = (e < 4) ? 8'd3 : (e < 8) ? 8'd2 : (e < 12) ? 8'd1 : 8'd0;
      exp_run  = (e < 12);
      exp_ring = (e >= 12 && e < 20);
      total++;
      if (a_tc !== exp_tc || a_run !== exp_run || a_ring !== exp_ring || a_mode !== 1'b1) begin
        bad++;
        $display("FAIL timer_edge%0d tc=%0d run=%b ring=%b mode=%b required tc=%0d run=%b ring=%b mode=1",
                 e, a_tc, a_run, a_ring, a_mode, exp_tc, exp_run, exp_ring);
      end
    end
  endtask

  task automatic test_priority();
    a_mode_in = 1; step(); a_mode_in = 0;
    total++;
    if (a_mode !== 1'b0 || a_tc !== 0) begin bad++; $display("FAIL prio_mode mode=%b tc=%0d required 0 0", a_mode, a_tc); end
    a_start = 1; step(); a_start = 0;
    for (int e = 1; e <= 20; e++) begin
      a_start = (e == 20); step(); a_start = 0;
    end
    total++;
    if (a_tc !== 8'd5 || a_run !== 1'b0) begin
      bad++; $display("FAIL prio_stop_tick tc=%0d run=%b required tc=5 run=0", a_tc, a_run);
    end
    a_start = 1; a_split = 1; step(); a_start = 0; a_split = 0;
    total++;
    if (a_run !== 1'b1 || a_tc !== 8'd5 || a_lv !== 1'b0) begin
      bad++; $display("FAIL prio_start_split run=%b tc=%0d lv=%b required run=1 tc=5 lv=0", a_run, a_tc, a_lv);
    end
    a_split = 1; step(); a_split = 0;
    total++;
    if (a_lv !== 1'b1 || a_ld !== 8'd5) begin
      bad++; $display("FAIL prio_lap lv=%b ld=%0d required lv=1 ld=5", a_lv, a_ld);
    end
    rst = 1; step(); rst = 0;
    total++;
    if (a_tc !== 0 || a_mode !== 0 || a_run !== 0 || a_ring !== 0 || a_ld !== 0 || a_lv !== 0 || a_ovf !== 0) begin
      bad++;
      $display("FAIL midrun_reset tc=%0d mode=%b run=%b ring=%b ld=%0d lv=%b ovf=%b, required all 0",
               a_tc, a_mode, a_run, a_ring, a_ld, a_lv, a_ovf);
    end
  endtask

  task automatic test_wrap();
    b_start = 1; step(); b_start = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      total++;
      if (b_tc !== 4'(k % 16) || b_ring !== 1'b0 || b_run !== 1'b1) begin
        bad++;
        $display("FAIL wrap_cycle%0d tc=%0d ring=%b run=%b required tc=%0d ring=0 run=1",
                 k, b_tc, b_ring, b_run, k % 16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stopwatch();
    test_push_pop_full();
    test_lap_overflow();
    test_timer();
    test_priority();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
